seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 1000, meaning clock cycles per digit slot; legal range is 4 or more.
REQ-002 The block SHALL have parameter BLANK, default 50, meaning all-digits-off cycles at the start of each slot; legal range is 1 to DIV-2.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port load, input, width 1: single-cycle strobe that offers value.
REQ-006 The block SHALL have port value, input, width 16: four hex nibbles, with nibble 0 = value[3:0] as the rightmost digit.
REQ-007 The block SHALL have port nibble, output, width 4: the current digit's code, fed to the per-digit 7-segment decoder.
REQ-008 The block SHALL have port digit_en, output, width 4: one-hot, active-high digit enable, with bit i selecting digit i.
REQ-009 The block SHALL have port frame, output, width 1: one-cycle pulse after the digit index wraps from 3 to 0.
REQ-010 The block SHALL have port load_ack, output, width 1: one-cycle pulse when a pending value becomes displayed.

Function
REQ-011 Prescaler cnt SHALL count 0..DIV-1 and then wrap to 0; the cycle where cnt==DIV-1 is the slot end.
REQ-012 Digit index idx SHALL advance 0→1→2→3→0 on each slot end.
REQ-013 The FSM SHALL have two states, BLANK and SHOW.
REQ-014 The FSM SHALL be in BLANK while cnt<BLANK, and SHOW while cnt>=BLANK.
REQ-015 BLANK→SHOW SHALL occur on the cnt==BLANK-1 edge.
REQ-016 SHOW→BLANK SHALL occur on the slot-end edge.
REQ-017 digit_en SHALL be 4'b0000 in BLANK, and in SHOW SHALL have only bit idx set.
REQ-018 At most one digit_en bit SHALL ever be set.
REQ-019 nibble SHALL be registered and equal disp[4*idx+3:4*idx] for the whole slot, including BLANK, so the decoder settles before enable.
REQ-020 A load SHALL capture value into the pend register and set pend_v.
REQ-021 Multiple loads before a frame boundary SHALL mean the last one wins, with only one load_ack.
REQ-022 The frame boundary is the slot end with idx==3; at that edge, if pend_v=1, the block SHALL do disp<=pend and clear pend_v, so there is no tearing mid-frame.
REQ-023 load asserted on the boundary cycle itself SHALL write value directly to disp and leave pend_v=0.
REQ-024 In the REQ-023 case, value SHALL take precedence over any older pending value.
REQ-025 load_ack SHALL pulse high for exactly the cycle after disp is updated by REQ-022 or REQ-023.
REQ-026 frame SHALL pulse high for exactly the cycle after every boundary, independent of load.
REQ-027 Latency from a load to visible digit 0 SHALL be at most 4*DIV+BLANK+1 cycles.

Reset
REQ-028 rst_n low SHALL immediately force cnt=0, idx=0, disp=16'h0000, pend=16'h0000, pend_v=0 and the BLANK state.
REQ-029 rst_n low SHALL immediately force nibble=0, digit_en=0, frame=0 and load_ack=0.
REQ-030 Reset mid-slot or mid-pending SHALL discard the pending value with no load_ack.
REQ-031 The first cycle after rst_n rises SHALL have cnt=0.

Configuration
REQ-032 With SEG7_LZB_EN defined, digit_en bit i for i>0 SHALL be forced 0 when disp[15:4*i] is all zero.
REQ-033 With SEG7_LZB_EN defined, digit 0 SHALL always be shown, and nibble and timing SHALL be unchanged.
REQ-034 With SEG7_LZB_EN undefined, all four digits SHALL scan regardless of value.

Verification (DIV=8, BLANK=2)
REQ-035 Release reset, no load: digit_en SHALL be 0 for cycles 0-1, then 4'b0001 for cycles 2-7, then 0 at cycle 8, then 4'b0010 at cycle 10; nibble SHALL be 0 throughout.
REQ-036 load with value=16'h1234 at cycle 5: disp SHALL be unchanged until the edge at cycle 31, then load_ack=1 and frame=1 at cycle 32; after that, nibble SHALL read 4,3,2,1 in slots 0-3.
REQ-037 load 16'hAAAA at cycle 3, then load 16'h5555 at cycle 9: exactly one load_ack SHALL occur, and disp SHALL be 16'h5555.
REQ-038 load 16'hBEEF exactly on the cycle-31 boundary with an older pend of 16'h1111: disp SHALL become 16'hBEEF, load_ack SHALL be 1 at cycle 32, and pend_v SHALL be 0.
REQ-039 rst_n pulsed low at cycle 20 with pend_v=1: all outputs SHALL go 0 immediately, and no load_ack SHALL follow.
REQ-040 With SEG7_LZB_EN defined, disp=16'h0042: digit_en SHALL be 0 for all of slots 2-3, and slots 0-1 SHALL show 2 and 4.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner: one digit per DIV-cycle slot, with blanking at slot start.
// New values are double-buffered and swapped in only at the frame boundary. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan #(
  parameter int DIV   = 1000,
  parameter int BLANK = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  nibble,
  output logic [3:0]  digit_en,
  output logic        frame,
  output logic        load_ack
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    nibble_q, nibble_d;
  logic [3:0]    digit_en_q, digit_en_d;
  logic          frame_q, frame_d;
  logic          load_ack_q, load_ack_d;
  logic          slot_end, boundary;
  logic [3:0]    lz_mask;

  always_comb begin
    slot_end   = (cnt_q == CW'(DIV - 1));
    boundary   = slot_end && (idx_q == 2'd3);

    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;

    state_d    = state_q;
    if (slot_end)
      state_d = ST_BLANK;
    else if (cnt_q == CW'(BLANK - 1))
      state_d = ST_SHOW;

    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    load_ack_d = 1'b0;
    // A load landing on the boundary itself bypasses pend and beats any older pending value.
    if (boundary) begin
      if (load) begin
        disp_d     = value;
        pend_v_d   = 1'b0;
        load_ack_d = 1'b1;
      end else if (pend_v_q) begin
        disp_d     = pend_q;
        pend_v_d   = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
    frame_d    = boundary;

    case (idx_d)
      2'd0:    nibble_d = disp_d[3:0];
      2'd1:    nibble_d = disp_d[7:4];
      2'd2:    nibble_d = disp_d[11:8];
      default: nibble_d = disp_d[15:12];
    endcase

`ifdef SEG7_LZB_EN
    lz_mask = {|disp_d[15:12], |disp_d[15:8], |disp_d[15:4], 1'b1};
`else
    lz_mask = 4'b1111;
`endif
    digit_en_d = (state_d == ST_SHOW) ? ((4'b0001 << idx_d) & lz_mask) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      disp_q     <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_v_q   <= 1'b0;
      nibble_q   <= 4'h0;
      digit_en_q <= 4'b0000;
      frame_q    <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      nibble_q   <= nibble_d;
      digit_en_q <= digit_en_d;
      frame_q    <= frame_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign nibble   = nibble_q;
  assign digit_en = digit_en_q;
  assign frame    = frame_q;
  assign load_ack = load_ack_q;

endmodule
